unified_mem_arbiter: RTL

Shares the single-ported unified instruction/data memory of the pipelined MIPS-32 core between the instruction-fetch port and the load/store port. Grants one transaction at a time, drives the memory command for one cycle, waits the fixed memory latency and returns the response to the owner. Data accesses win contention; a starvation guard forces a fetch grant after a bounded run of data grants.

---
 rtl/mips_mem_pkg.sv | 27 ++
 rtl/mem_arb_pick.sv | 48 ++++
 rtl/unified_mem_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and default sizing for the unified instruction/data memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_mem_pkg;

    localparam int unsigned AW_DEF         = 10;
    localparam int unsigned DW_DEF         = 32;
    localparam int unsigned MEM_LAT_DEF    = 1;
    localparam int unsigned STREAK_MAX_DEF = 4;

    // Streak counter holds 0..15; wait counter holds MEM_LAT-1 (0..3).
    localparam int unsigned STREAK_W = 4;
    localparam int unsigned LAT_W    = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way fetch/data priority pick with a starvation guard on the fetch side.
// Latency: grants are combinational; streak count updates on the grant edge.
// Backpressure: grants only while arb_en_i; a requester not granted simply keeps valid.
//
// Ports: clk_i/rst_ni clock and async active-low reset; arb_en_i arbitration window;
//        if_vld_i/dm_vld_i request valids; grant_if_o/grant_dm_o one-hot grants.
module mem_arb_pick
    import mips_mem_pkg::*;
#(
    parameter int unsigned STREAK_MAX = STREAK_MAX_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic arb_en_i,
    input  logic if_vld_i,
    input  logic dm_vld_i,
    output logic grant_if_o,
    output logic grant_dm_o
);

    logic [STREAK_W-1:0] streak_q;
    logic [STREAK_W-1:0] streak_d;
    logic                force_if;

    // Once data has won STREAK_MAX contended rounds in a row, fetch takes the next one.
    assign force_if = (streak_q == STREAK_W'(STREAK_MAX));

    always_comb begin
        grant_if_o = arb_en_i && if_vld_i && (!dm_vld_i || force_if);
        grant_dm_o = arb_en_i && dm_vld_i && !(if_vld_i && force_if);
        streak_d   = streak_q;
        if (grant_if_o) begin
            streak_d = '0;
        end else if (grant_dm_o && if_vld_i && !force_if) begin
            // Only contended data grants count; an idle fetch side is not being starved.
            streak_d = streak_q + STREAK_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported memory between the fetch port and the load/store port.
// Latency: accept at T, mem_en at T+1, response pulse at T+2+MEM_LAT.
// Backpressure: one transaction in flight; ready is offered only in IDLE or RESP.
//
// Ports: clk1/rst_n; if_req_* / if_rsp_* fetch port; dm_req_* / dm_rsp_* load/store port;
//        mem_* one-cycle memory command and returned read data; busy = not IDLE.
module unified_mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int unsigned AW         = AW_DEF,
    parameter int unsigned DW         = DW_DEF,
    parameter int unsigned MEM_LAT    = MEM_LAT_DEF,
    parameter int unsigned STREAK_MAX = STREAK_MAX_DEF
) (
    input  logic          clk1,
    input  logic          rst_n,
    input  logic          if_req_valid,
    input  logic [AW-1:0] if_addr,
    output logic          if_req_ready,
    output logic          if_rsp_valid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req_valid,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_req_ready,
    output logic          dm_rsp_valid,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    arb_state_e       state_q, state_d;
    owner_e           owner_q, owner_d;
    logic             we_q, we_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    if_rdata_q, if_rdata_d;
    logic [DW-1:0]    dm_rdata_q, dm_rdata_d;

    logic arb_en;
    logic grant_if;
    logic grant_dm;

    // RESP doubles as an arbitration slot so back-to-back requests lose no cycle.
    assign arb_en = (state_q == IDLE) || (state_q == RESP);

    mem_arb_pick #(
        .STREAK_MAX (STREAK_MAX)
    ) u_pick (
        .clk_i      (clk1),
        .rst_ni     (rst_n),
        .arb_en_i   (arb_en),
        .if_vld_i   (if_req_valid),
        .dm_vld_i   (dm_req_valid),
        .grant_if_o (grant_if),
        .grant_dm_o (grant_dm)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;

        case (state_q)
            IDLE, RESP: begin
                if (grant_dm) begin
                    owner_d = OWN_DM;
                    we_d    = dm_we;
                    addr_d  = dm_addr;
                    wdata_d = dm_wdata;
                    state_d = ISSUE;
                end else if (grant_if) begin
                    owner_d = OWN_IF;
                    we_d    = 1'b0;
                    addr_d  = if_addr;
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                cnt_d   = LAT_W'(MEM_LAT - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    // Stores leave dm_rdata untouched; only reads capture.
                    if (owner_q == OWN_IF) begin
                        if_rdata_d = mem_rdata;
                    end else if (!we_q) begin
                        dm_rdata_d = mem_rdata;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    assign if_req_ready = grant_if;
    assign dm_req_ready = grant_dm;
    assign if_rsp_valid = (state_q == RESP) && (owner_q == OWN_IF);
    assign dm_rsp_valid = (state_q == RESP) && (owner_q == OWN_DM);
    assign if_rdata     = if_rdata_q;
    assign dm_rdata     = dm_rdata_q;
    // Command fields sit on the latch; only mem_en/mem_we qualify them.
    assign mem_en       = (state_q == ISSUE);
    assign mem_we       = (state_q == ISSUE) && we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign busy         = (state_q != IDLE);

endmodule
